// File: rtl/dac_pkg.sv
// Shared types and constants for the quad DAC serial writer.
// Holds the FSM encoding, frame geometry, channel addresses and frame packing.
package dac_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        LOAD,
        GAP,
        LDAC,
        DONE
    } dac_state_t;

    localparam int FRAME_W     = 11;
    localparam int DEF_CLK_DIV = 4;

    localparam logic [1:0] ADDR_A = 2'd0;
    localparam logic [1:0] ADDR_B = 2'd1;
    localparam logic [1:0] ADDR_C = 2'd2;
    localparam logic [1:0] ADDR_D = 2'd3;

    // Wire order: A1 A0 RNG D7..D0, sent MSB first.
    function automatic logic [FRAME_W-1:0] dac_frame(input logic [1:0] addr,
                                                     input logic       rng,
                                                     input logic [7:0] dat);
        return {addr, rng, dat};
    endfunction

endpackage

// File: rtl/dac_tick_div.sv
// Serial-clock divider: one-cycle tick every CLK_DIV cycles while enabled.
// Latency: first tick CLK_DIV cycles after restart; no backpressure, free-running while en.
module dac_tick_div #(
    parameter int CLK_DIV = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic en,
    input  logic restart,
    output logic tick
);

    localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

    logic [7:0] cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt <= '0;
        end else if (restart || !en || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

    assign tick = en && !restart && (cnt == LAST);

endmodule

// File: rtl/dac_quad_writer.sv
// Writes four 8-bit channels to a TLC5620-style DAC, then strobes LDAC once.
// Latency: done 97*CLK_DIV cycles after accept; init ignored while busy (no queueing).
module dac_quad_writer
    import dac_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV,
    parameter int DATA_W  = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              init,
    input  logic              rng,
    input  logic [DATA_W-1:0] ch0,
    input  logic [DATA_W-1:0] ch1,
    input  logic [DATA_W-1:0] ch2,
    input  logic [DATA_W-1:0] ch3,
    output logic              DAC_CLK,
    output logic              DAC_DATA,
    output logic              DAC_LOAD,
    output logic              DAC_LDAC,
    output logic              busy,
    output logic              done
);

    dac_state_t                  state, state_nx;
    logic [3:0][DATA_W-1:0]      smp_q;
    logic                        rng_q;
    logic [3:0]                  bit_cnt;
    logic [1:0]                  ch_cnt;
    logic [1:0]                  ch_nxt;
    logic [FRAME_W-1:0]          sh_q;
    logic                        data_q;
    logic                        tick;
    logic                        accept;

    assign accept   = (state == IDLE) && init;
    assign ch_nxt   = ch_cnt + 2'd1;
    assign DAC_DATA = data_q;

    dac_tick_div #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_div (
        .CLK     (CLK),
        .RST     (RST),
        .en      (busy),
        .restart (accept),
        .tick    (tick)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        DAC_CLK  = 1'b0;
        DAC_LOAD = 1'b1;
        DAC_LDAC = 1'b1;
        busy     = 1'b1;
        done     = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (init) state_nx = SHIFT_LO;
            end
            SHIFT_LO: begin
                if (tick) state_nx = SHIFT_HI;
            end
            SHIFT_HI: begin
                DAC_CLK = 1'b1;
                if (tick) state_nx = (bit_cnt == 4'(FRAME_W - 1)) ? LOAD : SHIFT_LO;
            end
            LOAD: begin
                DAC_LOAD = 1'b0;
                if (tick) state_nx = GAP;
            end
            GAP: begin
                if (tick) state_nx = (ch_cnt == ADDR_D) ? LDAC : SHIFT_LO;
            end
            LDAC: begin
                DAC_LDAC = 1'b0;
                if (tick) state_nx = DONE;
            end
            DONE: begin
                busy     = 1'b0;
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                busy     = 1'b0;
                state_nx = IDLE;
            end
        endcase
    end

    // data_q is the bit on the wire; sh_q holds the bits still to go, MSB next.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            smp_q   <= '0;
            rng_q   <= 1'b0;
            bit_cnt <= '0;
            ch_cnt  <= '0;
            sh_q    <= '0;
            data_q  <= 1'b0;
        end else if (accept) begin
            smp_q            <= {ch3, ch2, ch1, ch0};
            rng_q            <= rng;
            bit_cnt          <= '0;
            ch_cnt           <= ADDR_A;
            {data_q, sh_q}   <= {dac_frame(ADDR_A, rng, ch0), 1'b0};
        end else if (tick) begin
            unique case (state)
                SHIFT_HI: begin
                    if (bit_cnt != 4'(FRAME_W - 1)) begin
                        bit_cnt        <= bit_cnt + 4'd1;
                        {data_q, sh_q} <= {sh_q, 1'b0};
                    end
                end
                GAP: begin
                    if (ch_cnt != ADDR_D) begin
                        ch_cnt         <= ch_nxt;
                        bit_cnt        <= '0;
                        {data_q, sh_q} <= {dac_frame(ch_nxt, rng_q, smp_q[ch_nxt]), 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dac_quad_writer.sv
// Directed bench for dac_quad_writer: instance 0 at CLK_DIV=4, instance 1 at CLK_DIV=1.
// A negedge monitor decodes frames and counts strobes/invariant breaks; the main flow compares.
module tb_dac_quad_writer;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       init4 = 1'b0;
    logic       init1 = 1'b0;
    logic       rng = 1'b0;
    logic [7:0] ch0 = '0, ch1 = '0, ch2 = '0, ch3 = '0;

    logic [1:0] dclk, ddat, dload, dldac, busy, done;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    dac_quad_writer #(.CLK_DIV(4), .DATA_W(8)) u4 (
        .CLK(CLK), .RST(RST), .init(init4), .rng(rng),
        .ch0(ch0), .ch1(ch1), .ch2(ch2), .ch3(ch3),
        .DAC_CLK(dclk[0]), .DAC_DATA(ddat[0]), .DAC_LOAD(dload[0]), .DAC_LDAC(dldac[0]),
        .busy(busy[0]), .done(done[0])
    );

    dac_quad_writer #(.CLK_DIV(1), .DATA_W(8)) u1 (
        .CLK(CLK), .RST(RST), .init(init1), .rng(rng),
        .ch0(ch0), .ch1(ch1), .ch2(ch2), .ch3(ch3),
        .DAC_CLK(dclk[1]), .DAC_DATA(ddat[1]), .DAC_LOAD(dload[1]), .DAC_LDAC(dldac[1]),
        .busy(busy[1]), .done(done[1])
    );

    // Monitor state, per instance.
    logic [10:0] sh [2];
    logic [10:0] frames [2][32];
    int  nbits [2], nfr [2], badlen [2];
    int  load_cyc [2], load_pul [2], ldac_cyc [2], ldac_pul [2];
    int  inv_err [2], stab_err [2], acc_cnt [2], acc_cyc [2], done_cyc [2];
    bit  pclk [2], pdat [2], pload [2], pldac [2], pbusy [2];

    always @(negedge CLK) begin
        for (int i = 0; i < 2; i++) begin
            if (RST) begin
                nbits[i] = 0;
                sh[i]    = '0;
            end else begin
                if (dclk[i]) begin
                    if (!pclk[i]) begin
                        sh[i] = {sh[i][9:0], ddat[i]};
                        nbits[i]++;
                    end else if (ddat[i] != pdat[i]) begin
                        stab_err[i]++;
                    end
                end
                if (!dload[i] && pload[i]) begin
                    frames[i][nfr[i] % 32] = sh[i];
                    if (nbits[i] != 11) badlen[i]++;
                    nfr[i]++;
                    nbits[i] = 0;
                    load_pul[i]++;
                end
                if (!dload[i]) load_cyc[i]++;
                if (!dldac[i] && pldac[i]) ldac_pul[i]++;
                if (!dldac[i]) ldac_cyc[i]++;
                if ((!dload[i] && !dldac[i]) || ((!dload[i] || !dldac[i]) && dclk[i]))
                    inv_err[i]++;
                if (busy[i] && !pbusy[i]) begin
                    acc_cyc[i] = cyc;
                    acc_cnt[i]++;
                end
                if (done[i]) done_cyc[i] = cyc;
            end
            pclk[i]  = dclk[i];
            pdat[i]  = ddat[i];
            pload[i] = dload[i];
            pldac[i] = dldac[i];
            pbusy[i] = busy[i];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start(input int i);
        @(negedge CLK);
        if (i == 0) init4 = 1'b1;
        else        init1 = 1'b1;
        @(negedge CLK);
        init4 = 1'b0;
        init1 = 1'b0;
    endtask

    task automatic wait_done(input int i, input int bound);
        int n = 0;
        while (!done[i] && n < bound) begin
            @(negedge CLK);
            n++;
        end
        if (!done[i]) chk("done_timeout", 32'd0, 32'd1);
        #1;
    endtask

    task automatic chk_frames(input int i, input int base,
                              input logic [10:0] e0, input logic [10:0] e1,
                              input logic [10:0] e2, input logic [10:0] e3);
        logic [10:0] e [4];
        e = '{e0, e1, e2, e3};
        for (int k = 0; k < 4; k++)
            chk($sformatf("frame%0d_u%0d", k, i), 32'(frames[i][(base + k) % 32]), 32'(e[k]));
    endtask

    task automatic chk_reset_outs(input int i, input string tag);
        chk(tag, {26'd0, dclk[i], ddat[i], dload[i], dldac[i], busy[i], done[i]}, 32'b001100);
    endtask

    int b_fr, b_lc, b_lp, b_dc, b_dp, b_acc;

    initial begin
        repeat (3) @(negedge CLK);
        #1;
        chk_reset_outs(0, "reset_u4");
        chk_reset_outs(1, "reset_u1");
        RST = 1'b0;

        // Basic write, input snapshot, and two ignored init pulses.
        rng = 1'b1; ch0 = 8'hA5; ch1 = 8'h3C; ch2 = 8'hFF; ch3 = 8'h00;
        b_fr = nfr[0]; b_lc = load_cyc[0]; b_lp = load_pul[0];
        b_dc = ldac_cyc[0]; b_dp = ldac_pul[0]; b_acc = acc_cnt[0];
        start(0);
        repeat (9) @(negedge CLK);
        ch2 = 8'h11;
        repeat (40) @(negedge CLK);
        init4 = 1'b1;
        @(negedge CLK);
        init4 = 1'b0;
        wait_done(0, 500);
        chk("latency_div4", done_cyc[0] - acc_cyc[0], 388);
        init4 = 1'b1;
        @(negedge CLK);
        #1;
        chk("busy_after_done", busy[0], 0);
        init4 = 1'b0;
        repeat (30) @(negedge CLK);
        #1;
        chk("accepts", acc_cnt[0] - b_acc, 1);
        chk("frame_count", nfr[0] - b_fr, 4);
        chk_frames(0, b_fr, 11'b001_1010_0101, 11'b011_0011_1100,
                            11'b101_1111_1111, 11'b111_0000_0000);
        chk("load_pulses", load_pul[0] - b_lp, 4);
        chk("load_cycles", load_cyc[0] - b_lc, 16);
        chk("ldac_pulses", ldac_pul[0] - b_dp, 1);
        chk("ldac_cycles", ldac_cyc[0] - b_dc, 4);

        // Reset during channel 1 bit 5, then a clean rerun.
        ch0 = 8'h12; ch1 = 8'h34; ch2 = 8'h56; ch3 = 8'h78;
        b_fr = nfr[0]; b_dp = ldac_pul[0];
        start(0);
        repeat (24 * 4 + 10 * 4 + 2) @(negedge CLK);
        #1;
        chk("busy_before_rst", busy[0], 1);
        #1;
        RST = 1'b1;
        #1;
        chk_reset_outs(0, "reset_midop");
        @(negedge CLK);
        @(negedge CLK);
        #2;
        RST = 1'b0;
        repeat (5) @(negedge CLK);
        #1;
        chk("frames_before_rst", nfr[0] - b_fr, 1);
        chk("frame_pre_rst", 32'(frames[0][b_fr % 32]), 32'(11'b001_0001_0010));
        chk("no_ldac_on_rst", ldac_pul[0] - b_dp, 0);
        b_fr = nfr[0]; b_dp = ldac_pul[0];
        start(0);
        wait_done(0, 500);
        chk("latency_rerun", done_cyc[0] - acc_cyc[0], 388);
        chk_frames(0, b_fr, 11'b001_0001_0010, 11'b011_0011_0100,
                            11'b101_0101_0110, 11'b111_0111_1000);
        chk("ldac_rerun", ldac_pul[0] - b_dp, 1);

        // Minimum divider.
        ch0 = 8'h01; ch1 = 8'h80; ch2 = 8'h55; ch3 = 8'hAA;
        b_fr = nfr[1]; b_dp = ldac_pul[1]; b_lc = load_cyc[1];
        start(1);
        wait_done(1, 200);
        chk("latency_div1", done_cyc[1] - acc_cyc[1], 97);
        repeat (3) @(negedge CLK);
        #1;
        chk_frames(1, b_fr, 11'b001_0000_0001, 11'b011_1000_0000,
                            11'b101_0101_0101, 11'b111_1010_1010);
        chk("load_cycles_div1", load_cyc[1] - b_lc, 4);
        chk("ldac_div1", ldac_pul[1] - b_dp, 1);

        // Range bit clear.
        rng = 1'b0; ch0 = 8'h7F; ch1 = 8'h7F; ch2 = 8'h7F; ch3 = 8'h7F;
        b_fr = nfr[0];
        start(0);
        wait_done(0, 500);
        repeat (3) @(negedge CLK);
        #1;
        chk_frames(0, b_fr, 11'b000_0111_1111, 11'b010_0111_1111,
                            11'b100_0111_1111, 11'b110_0111_1111);

        for (int i = 0; i < 2; i++) begin
            chk($sformatf("invariants_u%0d", i), inv_err[i], 0);
            chk($sformatf("data_stable_u%0d", i), stab_err[i], 0);
            chk($sformatf("frame_len_u%0d", i), badlen[i], 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
